// File: rtl/pc_sequencer.sv
// Program-counter fetch sequencer: owns the PC, runs the instruction-memory
// req/ack handshake, holds the fetched instruction and selects the next PC.
module pc_sequencer #(
    parameter int unsigned      n_bit     = 32,
    parameter logic [n_bit-1:0] RESET_VEC = '0,
    parameter logic [n_bit-1:0] EXC_VEC   = n_bit'('h80),
    parameter int unsigned      TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [n_bit-1:0] branch_target,
    input  logic             jump,
    input  logic [n_bit-1:0] jump_target,
    input  logic             exc_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             imem_req,
    output logic [n_bit-1:0] imem_addr,
    output logic [n_bit-1:0] pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [n_bit-1:0] epc,
    output logic             fetch_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [n_bit-1:0] ALIGN_MASK = ~n_bit'(3);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [n_bit-1:0] pc_q, pc_d;
    logic [n_bit-1:0] epc_q, epc_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic [n_bit-1:0] next_pc;

    // Next-state, redirect selection and timeout detection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        pend_d  = pend_q | exc_req;
        cnt_d   = cnt_q;

        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

        if (jump) begin
            next_pc = jump_target & ALIGN_MASK;
        end else if (branch_taken) begin
            next_pc = branch_target & ALIGN_MASK;
        end else begin
            next_pc = pc_q + n_bit'(4);
        end

        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (timeout_hit) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VEC;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_EXEC: begin
                // Exceptions only taken at a non-stalled instruction boundary
                if (!stall) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                    if (pend_q || exc_req) begin
                        epc_d  = next_pc;
                        pc_d   = EXC_VEC;
                        pend_d = 1'b0;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            S_ABORT: state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request drops immediately while reset is held
    assign imem_req    = (state_q == S_FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign epc         = epc_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan sequences plus random traffic,
// checked every cycle against a stepped behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        exc_req = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req32, fetch_err32, instr_valid32;
    logic [31:0] imem_addr32, pc32, instr32, epc32;
    logic        imem_req8, fetch_err8, instr_valid8;
    logic [7:0]  imem_addr8, pc8, epc8;
    logic [31:0] instr8;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(.n_bit(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_req(imem_req32), .imem_addr(imem_addr32), .pc(pc32),
        .instr(instr32), .instr_valid(instr_valid32), .epc(epc32),
        .fetch_err(fetch_err32)
    );

    pc_sequencer #(.n_bit(8), .TIMEOUT(0)) dut8 (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
        .jump(jump), .jump_target(jump_target[7:0]), .exc_req(exc_req),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_req(imem_req8), .imem_addr(imem_addr8), .pc(pc8),
        .instr(instr8), .instr_valid(instr_valid8), .epc(epc8),
        .fetch_err(fetch_err8)
    );

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_ABORT = 2;

    typedef struct {
        int                phase;
        longint unsigned   pc;
        longint unsigned   epc;
        logic [31:0]       instr;
        bit                valid;
        bit                err;
        bit                pend;
        int unsigned       waited;
    } mst_t;

    mst_t m[2];

    // One clock of the architectural behaviour for a core of width w
    function automatic mst_t mstep(mst_t s, int unsigned w, int unsigned tmo);
        mst_t            n = s;
        longint unsigned mask;
        longint unsigned tgt;
        bit              pend_now;
        mask = (64'd1 << w) - 64'd1;
        n.err = 1'b0;
        if (reset) begin
            n.phase = PH_FETCH; n.pc = 0; n.epc = 0; n.instr = '0;
            n.valid = 1'b0; n.pend = 1'b0; n.waited = 0;
            return n;
        end
        pend_now = s.pend || exc_req;
        n.pend = pend_now;
        if (s.phase == PH_FETCH) begin
            if (imem_ack) begin
                n.instr = imem_rdata; n.valid = 1'b1; n.waited = 0; n.phase = PH_EXEC;
            end else begin
                n.waited = s.waited + 1;
                if (tmo != 0 && n.waited == tmo) begin
                    n.epc = s.pc; n.pc = 64'h80 & mask; n.err = 1'b1;
                    n.waited = 0; n.phase = PH_ABORT;
                end
            end
        end else if (s.phase == PH_ABORT) begin
            n.phase = PH_FETCH;
        end else if (!stall) begin
            if (jump)              tgt = 64'(jump_target) & ~64'd3;
            else if (branch_taken) tgt = 64'(branch_target) & ~64'd3;
            else                   tgt = s.pc + 64'd4;
            tgt = tgt & mask;
            if (pend_now) begin
                n.epc = tgt; n.pc = 64'h80 & mask; n.pend = 1'b0;
            end else begin
                n.pc = tgt;
            end
            n.valid = 1'b0;
            n.phase = PH_FETCH;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m[0] = mstep(m[0], 32, 4);
        m[1] = mstep(m[1], 8, 0);
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("pc32",    64'(pc32),          m[0].pc);
            chk("addr32",  64'(imem_addr32),   m[0].pc);
            chk("instr32", 64'(instr32),       64'(m[0].instr));
            chk("valid32", 64'(instr_valid32), 64'(m[0].valid));
            chk("epc32",   64'(epc32),         m[0].epc);
            chk("err32",   64'(fetch_err32),   64'(m[0].err));
            chk("req32",   64'(imem_req32),    64'(m[0].phase == PH_FETCH && !reset));
            chk("pc8",     64'(pc8),           m[1].pc);
            chk("addr8",   64'(imem_addr8),    m[1].pc);
            chk("instr8",  64'(instr8),        64'(m[1].instr));
            chk("valid8",  64'(instr_valid8),  64'(m[1].valid));
            chk("epc8",    64'(epc8),          m[1].epc);
            chk("err8",    64'(fetch_err8),    64'(m[1].err));
            chk("req8",    64'(imem_req8),     64'(m[1].phase == PH_FETCH && !reset));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        checking = 1'b1;
        tick();
        chk("rst_pc", 64'(pc32), 64'h0);
        chk("rst_valid", 64'(instr_valid32), 64'h0);
        chk("rst_epc", 64'(epc32), 64'h0);
        chk("rst_instr", 64'(instr32), 64'h0);
        reset = 1'b0;

        // Linear fetch, then wait states with ack on the 4th cycle, then stall
        imem_ack = 1'b1; imem_rdata = 32'h20080001; tick();
        chk("lin_instr", 64'(instr32), 64'h20080001);
        chk("lin_valid", 64'(instr_valid32), 64'h1);
        imem_ack = 1'b0; tick();
        chk("lin_pc4", 64'(pc32), 64'h4);
        chk("lin_valid0", 64'(instr_valid32), 64'h0);
        tick(); tick(); tick();
        imem_ack = 1'b1; imem_rdata = 32'h20090002; tick();
        chk("ack4_noerr", 64'(fetch_err32), 64'h0);
        chk("ack4_instr", 64'(instr32), 64'h20090002);
        imem_ack = 1'b0; stall = 1'b1; tick(); tick();
        chk("stall_pc", 64'(pc32), 64'h4);
        chk("stall_instr", 64'(instr32), 64'h20090002);
        stall = 1'b0; tick();
        chk("after_stall_pc", 64'(pc32), 64'h8);

        // Pending exception from a FETCH pulse
        exc_req = 1'b1; tick();
        exc_req = 1'b0; imem_ack = 1'b1; tick();
        imem_ack = 1'b0; tick();
        chk("pend_epc", 64'(epc32), 64'hC);
        chk("pend_pc", 64'(pc32), 64'h80);

        // Redirect priority and target alignment
        imem_ack = 1'b1; tick();
        imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h100;
        branch_taken = 1'b1; branch_target = 32'h40; tick();
        chk("jump_prio", 64'(pc32), 64'h100);
        jump = 1'b0; branch_taken = 1'b0;
        imem_ack = 1'b1; tick();
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h43; tick();
        chk("branch_align", 64'(pc32), 64'h40);
        branch_taken = 1'b0;
        imem_ack = 1'b1; tick();
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h40; exc_req = 1'b1; tick();
        chk("exc_branch_epc", 64'(epc32), 64'h40);
        chk("exc_branch_pc", 64'(pc32), 64'h80);
        branch_taken = 1'b0; exc_req = 1'b0;

        // Fetch timeout at 0x10
        imem_ack = 1'b1; tick();
        imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h10; tick();
        jump = 1'b0;
        tick(); tick(); tick(); tick();
        chk("tmo_err", 64'(fetch_err32), 64'h1);
        chk("tmo_epc", 64'(epc32), 64'h10);
        chk("tmo_pc", 64'(pc32), 64'h80);
        chk("tmo_req0", 64'(imem_req32), 64'h0);
        tick();
        chk("tmo_err_drop", 64'(fetch_err32), 64'h0);
        chk("tmo_req1", 64'(imem_req32), 64'h1);
        chk("tmo_addr", 64'(imem_addr32), 64'h80);

        // Reset in EXEC at 0x24
        imem_ack = 1'b1; tick();
        imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h24; tick();
        jump = 1'b0; imem_ack = 1'b1; tick();
        chk("exec24_pc", 64'(pc32), 64'h24);
        imem_ack = 1'b0; reset = 1'b1; tick();
        chk("midrst_pc", 64'(pc32), 64'h0);
        chk("midrst_valid", 64'(instr_valid32), 64'h0);
        reset = 1'b0;

        // Sequential step from 0xFC: wraps on the 8-bit core only
        imem_ack = 1'b1; tick();
        imem_ack = 1'b0; jump = 1'b1; jump_target = 32'hFC; tick();
        jump = 1'b0; imem_ack = 1'b1; tick();
        imem_ack = 1'b0; tick();
        chk("wrap_pc8", 64'(pc8), 64'h0);
        chk("nowrap_pc32", 64'(pc32), 64'h100);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            stall         = ($urandom_range(0, 2) == 0);
            imem_ack      = ($urandom_range(0, 3) == 0);
            imem_rdata    = $urandom;
            exc_req       = ($urandom_range(0, 15) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            jump_target   = $urandom;
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            tick();
        end

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch sequencer for the single-cycle MIPS core's program counter. It owns the PC register and runs the instruction-memory request/acknowledge handshake. It holds each fetched instruction while the datapath executes it, then selects the next PC from exception, jump, branch or sequential sources. A fetch timeout redirects the core to the exception vector when instruction memory does not respond.

## Interface
- n_bit, 32: PC/address width; minimum 3
- RESET_VEC, 0: PC value loaded by reset
- EXC_VEC, 'h80: PC loaded on exception or fetch timeout
- TIMEOUT, 16: FETCH cycles without ack before a fetch error; 0 disables the timeout
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  datapath hold; keeps the current instruction in EXEC
- branch_taken  in  1  branch resolved taken
- branch_target  in  n_bit  branch destination
- jump  in  1  jump/jr
- jump_target  in  n_bit  jump destination
- exc_req  in  1  exception/interrupt request; level or pulse
- imem_ack  in  1  instruction memory data valid
- imem_rdata  in  32  instruction word
- imem_req  out  1  fetch request
- imem_addr  out  n_bit  fetch address; always equals pc
- pc  out  n_bit  current PC
- instr  out  32  held instruction
- instr_valid  out  1  instr is valid for execution
- epc  out  n_bit  exception return address
- fetch_err  out  1  one-cycle pulse on timeout

## Operation
- States: FETCH, EXEC, ABORT.
- Reset (any state, any inputs):
  - pc=RESET_VEC, state=FETCH.
  - instr=0, instr_valid=0, epc=0, fetch_err=0, exc_pend=0, timeout count=0.
  - imem_req=0 while reset is high.
- FETCH:
  - imem_req=1.
  - imem_ack=1 captures imem_rdata into instr, clears the counter, and moves to EXEC.
  - Otherwise the counter increments.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT: epc<=pc, pc<=EXC_VEC, fetch_err=1 for one cycle, move to ABORT.
- ABORT:
  - Lasts one cycle with imem_req=0, then returns to FETCH.
- EXEC:
  - instr_valid=1, imem_req=0.
  - If stall=1: hold state, pc and instr; redirect inputs are ignored.
  - If stall=0: resolve next PC, update pc, return to FETCH.
- Next-PC priority:
  - jump gives jump_target.
  - else branch_taken gives branch_target.
  - else pc+4, wrapping modulo 2^n_bit.
  - Bits [1:0] of jump_target and branch_target are forced to 0.
- Exceptions:
  - exc_req=1 in any non-reset cycle sets sticky exc_pend.
  - At an EXEC cycle with stall=0 and (exc_pend or exc_req): epc<=resolved next PC, pc<=EXC_VEC, exc_pend cleared.
  - Exceptions are never taken in FETCH, ABORT or a stalled EXEC.
- Timeout vs. pending exception: on a timeout, exc_pend is preserved and taken at the next instruction boundary.
- imem_ack outside FETCH is ignored, and imem_rdata is not sampled.

## Timing
- Minimum of 2 cycles per instruction: FETCH with same-cycle ack, then EXEC.
- Wait states extend FETCH by one cycle per cycle without ack.
- instr and instr_valid become valid the cycle after the ack edge.
- pc changes on the clock edge that ends a non-stalled EXEC, a timeout, or reset.
- imem_addr is combinationally equal to pc.
- fetch_err is high during the first ABORT cycle only.
- The timeout fires after exactly TIMEOUT FETCH cycles with no ack.
- An ack arriving in the same cycle as the TIMEOUT-th count wins: the instruction is captured and no error is raised.
- Reset asserted mid-FETCH or mid-EXEC takes effect at that edge; any in-flight ack is discarded.
- After reset deasserts, imem_req=1 in the first cycle.

## Test plan
- Reset then linear fetch:
  - Stimulus: reset 2 cycles; ack the same cycle as each req; rdata=0x20080001, 0x20090002.
  - Required: pc steps 0→4→8; instr_valid high every other cycle; epc=0.
- Wait states and stall:
  - Stimulus: ack after 3 FETCH cycles; stall=1 for 2 EXEC cycles.
  - Required: pc held at 4 throughout; instr stable; next pc=8.
- Redirect priority:
  - Stimulus: in EXEC, jump=1 with jump_target=0x100, and branch_taken=1 with branch_target=0x40.
  - Required: pc=0x100.
  - Stimulus: branch only, with target 0x43.
  - Required: pc=0x40.
- Pending exception:
  - Stimulus: 1-cycle exc_req pulse during FETCH at pc=0x8.
  - Required: at the following non-stalled EXEC, epc=0xC and pc=0x80.
  - Stimulus: exc_req coincident with a branch to 0x40.
  - Required: epc=0x40.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack at pc=0x10.
  - Required: fetch_err pulses 1 cycle after the 4th FETCH cycle; epc=0x10; pc=0x80; one imem_req=0 cycle; then req resumes at 0x80.
  - Stimulus: ack on the 4th cycle.
  - Required: no error.
- Mid-operation reset and wrap:
  - Stimulus: reset asserted in EXEC at pc=0x24.
  - Required: pc=0, instr_valid=0 next cycle.
  - Stimulus: n_bit=8 with pc=0xFC, sequential step.
  - Required: pc=0x00.
